// File: rtl/bp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_pkg : counter encodings and saturating-counter helpers shared    |
// |          by the branch predictor and its history table.             |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package bp_pkg;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  // Helpers work on a wide container so any CTR_BITS up to this fits.
  localparam int CTR_W_MAX = 16;
  typedef logic [CTR_W_MAX-1:0] ctr_t;

  function automatic ctr_t ctr_next(ctr_t ctr, logic taken, int unsigned bits);
    ctr_t top;
    ctr_t nxt;
    top = ctr_t'((32'd1 << bits) - 32'd1);
    nxt = ctr;
    if (taken && (ctr != top)) begin
      nxt = ctr + ctr_t'(1);
    end else if (!taken && (ctr != '0)) begin
      nxt = ctr - ctr_t'(1);
    end
    return nxt;
  endfunction

  // 10..0 when taken, 01..1 otherwise; degenerates to the outcome for 1 bit.
  function automatic ctr_t weak_init(logic taken, int unsigned bits);
    ctr_t half;
    half = ctr_t'(32'd1 << (bits - 32'd1));
    return taken ? half : (half - ctr_t'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branch_predictor_if : lookup / prediction / update bundle between   |
// |                       the pipeline and the predictor.              |
// | History signals exist only when BP_GSHARE_EN is defined.           |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface branch_predictor_if
`ifdef BP_GSHARE_EN
  #(parameter int HIST_BITS = 8)
`endif
  ;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic [31:0] lookup_imme;
  logic        stall;
  logic        flush;
  logic        pred_valid;
  logic        pred_take;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0] pred_hist;
  logic [HIST_BITS-1:0] update_hist;
`endif

  modport master (
    output lookup_valid, lookup_pc, lookup_imme, stall, flush,
    output update_valid, update_pc, update_taken,
    input  pred_valid, pred_take, pred_target, pred_hit
`ifdef BP_GSHARE_EN
    , input pred_hist, output update_hist
`endif
  );

  modport slave (
    input  lookup_valid, lookup_pc, lookup_imme, stall, flush,
    input  update_valid, update_pc, update_taken,
    output pred_valid, pred_take, pred_target, pred_hit
`ifdef BP_GSHARE_EN
    , output pred_hist, input update_hist
`endif
  );

endinterface
`default_nettype wire

// File: rtl/bp_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_table : direct-mapped valid/tag/counter store, one read and one  |
// |            write port, write-first bypass on an index collision.    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module bp_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 10,
  parameter int CTR_BITS   = 2,
  parameter int TAG_BITS   = 20
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic [INDEX_BITS-1:0] rd_idx,
  input  wire logic [TAG_BITS-1:0]   rd_tag,
  output logic                       rd_hit,
  output logic                       rd_ctr_msb,
  input  wire logic                  wr_en,
  input  wire logic [INDEX_BITS-1:0] wr_idx,
  input  wire logic [TAG_BITS-1:0]   wr_tag,
  input  wire logic                  wr_taken
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [DEPTH-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag [DEPTH];
  logic [CTR_BITS-1:0] r_ctr [DEPTH];

  logic                w_wr_hit;
  logic [CTR_BITS-1:0] w_wr_ctr;

  assign w_wr_hit = r_valid[wr_idx] && (r_tag[wr_idx] == wr_tag);
  assign w_wr_ctr = w_wr_hit
                  ? CTR_BITS'(ctr_next(ctr_t'(r_ctr[wr_idx]), wr_taken, CTR_BITS))
                  : CTR_BITS'(weak_init(wr_taken, CTR_BITS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (wr_en) begin
      r_valid[wr_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_tag[wr_idx] <= wr_tag;
      r_ctr[wr_idx] <= w_wr_ctr;
    end
  end

  always_comb begin
    rd_hit     = r_valid[rd_idx] && (r_tag[rd_idx] == rd_tag);
    rd_ctr_msb = r_ctr[rd_idx][CTR_BITS-1];
    if (wr_en && (wr_idx == rd_idx)) begin
      rd_hit     = (wr_tag == rd_tag);
      rd_ctr_msb = w_wr_ctr[CTR_BITS-1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branch_predictor : tagged BHT predictor with registered 1-cycle     |
// |                    prediction; BP_GSHARE_EN adds gshare indexing.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS   = 10,
  parameter int CTR_BITS     = 2,
  parameter int DEFAULT_TAKE = 1,
  parameter int HIST_BITS    = 8
) (
  input wire logic          clk,
  input wire logic          reset,
  branch_predictor_if.slave bus
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [HIST_BITS-1:0]  w_lkp_hist;
  logic [HIST_BITS-1:0]  w_upd_hist;
  logic [INDEX_BITS-1:0] w_lkp_idx;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0]   w_lkp_tag;
  logic [TAG_BITS-1:0]   w_upd_tag;
  logic                  w_hit;
  logic                  w_ctr_msb;
  logic                  w_take;
  logic [31:0]           w_target;
  logic                  w_unused;

  logic        r_pred_valid;
  logic        r_pred_take;
  logic        r_pred_hit;
  logic [31:0] r_pred_target;

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0] r_hist;
  logic [HIST_BITS-1:0] r_pred_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
    end else if (bus.update_valid) begin
      r_hist <= HIST_BITS'({r_hist, bus.update_taken});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pred_hist <= '0;
    end else if (!bus.flush && !bus.stall && bus.lookup_valid) begin
      r_pred_hist <= w_lkp_hist;
    end
  end

  assign w_lkp_hist    = r_hist;
  assign w_upd_hist    = bus.update_hist;
  assign bus.pred_hist = r_pred_hist;
`else
  assign w_lkp_hist = '0;
  assign w_upd_hist = '0;
`endif

  // History only perturbs the index; the tag always comes from the PC.
  assign w_lkp_idx = bus.lookup_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(w_lkp_hist);
  assign w_upd_idx = bus.update_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(w_upd_hist);
  assign w_lkp_tag = bus.lookup_pc[31:INDEX_BITS+2];
  assign w_upd_tag = bus.update_pc[31:INDEX_BITS+2];
  assign w_unused  = &{1'b0, bus.lookup_pc[1:0], bus.update_pc[1:0]};

  bp_table #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (w_lkp_idx),
    .rd_tag     (w_lkp_tag),
    .rd_hit     (w_hit),
    .rd_ctr_msb (w_ctr_msb),
    .wr_en      (bus.update_valid),
    .wr_idx     (w_upd_idx),
    .wr_tag     (w_upd_tag),
    .wr_taken   (bus.update_taken)
  );

  assign w_take   = w_hit ? w_ctr_msb : (DEFAULT_TAKE != 0);
  assign w_target = w_take ? (bus.lookup_pc + bus.lookup_imme)
                           : (bus.lookup_pc + 32'd4);

  // Flush outranks stall so a killed prediction never survives a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pred_valid  <= 1'b0;
      r_pred_take   <= 1'b0;
      r_pred_hit    <= 1'b0;
      r_pred_target <= '0;
    end else if (bus.flush) begin
      r_pred_valid  <= 1'b0;
    end else if (!bus.stall) begin
      r_pred_valid <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        r_pred_take   <= w_take;
        r_pred_hit    <= w_hit;
        r_pred_target <= w_target;
      end
    end
  end

  assign bus.pred_valid  = r_pred_valid;
  assign bus.pred_take   = r_pred_take;
  assign bus.pred_hit    = r_pred_hit;
  assign bus.pred_target = r_pred_target;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_branch_predictor : directed vector table plus reset and gshare   |
// |                       sequences against hand-computed results.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_branch_predictor;
  import bp_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  branch_predictor_if
`ifdef BP_GSHARE_EN
    #(.HIST_BITS(8))
`endif
    bus ();

  branch_predictor #(
    .INDEX_BITS   (10),
    .CTR_BITS     (2),
    .DEFAULT_TAKE (1),
    .HIST_BITS    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [31:0] pc;
    logic [31:0] imme;
    logic        st;
    logic        fl;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        ev;
    logic        chk;
    logic        etake;
    logic        ehit;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic lv, logic [31:0] pc, logic [31:0] imme,
                              logic st, logic fl, logic uv, logic [31:0] upc,
                              logic ut, logic ev, logic chk, logic etake,
                              logic ehit, logic [31:0] etgt);
    vec_t v;
    v.lv = lv; v.pc = pc; v.imme = imme; v.st = st; v.fl = fl;
    v.uv = uv; v.upc = upc; v.ut = ut; v.ev = ev; v.chk = chk;
    v.etake = etake; v.ehit = ehit; v.etgt = etgt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.lookup_valid = 1'b0;
    bus.lookup_pc    = '0;
    bus.lookup_imme  = '0;
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    bus.update_valid = 1'b0;
    bus.update_pc    = '0;
    bus.update_taken = 1'b0;
`ifdef BP_GSHARE_EN
    bus.update_hist  = '0;
`endif
  endtask

  initial begin
    logic [1:0] weak_nt;
    total = 0;
    bad   = 0;
    weak_nt = CTR_WEAK_NT;
    idle_inputs();
    reset = 1'b1;

    //      lv pc            imme          st fl uv upc           ut ev chk tk hit tgt
    vecs.push_back(mk(1, 32'h100,      32'h40, 0, 0, 0, 32'h0,    0, 1, 1, 1, 0, 32'h140));
    vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 32'h100,  0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      32'h40, 0, 0, 0, 32'h0,    0, 1, 1, weak_nt[1], 1, 32'h104));
    vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 32'h100,  0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      32'h40, 0, 0, 0, 32'h0,    0, 1, 1, 0, 1, 32'h104));
    vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 32'h100,  0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 32'h100,  1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      32'h40, 0, 0, 0, 32'h0,    0, 1, 1, 0, 1, 32'h104));
    vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 32'h100,  1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      32'h40, 0, 0, 0, 32'h0,    0, 1, 1, 1, 1, 32'h140));
    vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 32'h1100, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      32'h40, 0, 0, 0, 32'h0,    0, 1, 1, 1, 0, 32'h140));
    vecs.push_back(mk(1, 32'h1100,     32'h8,  0, 0, 0, 32'h0,    0, 1, 1, 0, 1, 32'h1104));
    vecs.push_back(mk(1, 32'h200,      32'h20, 0, 0, 1, 32'h200,  1, 1, 1, 1, 1, 32'h220));
    vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 32'h200,  1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 32'h200,  1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h200,      32'h20, 0, 0, 1, 32'h200,  0, 1, 1, 1, 1, 32'h220));
    vecs.push_back(mk(1, 32'h200,      32'h20, 0, 0, 1, 32'h200,  0, 1, 1, 0, 1, 32'h204));
    vecs.push_back(mk(1, 32'h200,      32'h20, 0, 0, 1, 32'h1200, 1, 1, 1, 1, 0, 32'h220));
    vecs.push_back(mk(1, 32'h1203,     32'h10, 0, 0, 0, 32'h0,    0, 1, 1, 1, 1, 32'h1213));
    vecs.push_back(mk(1, 32'h1100,     32'h8,  0, 0, 0, 32'h0,    0, 1, 1, 0, 1, 32'h1104));
    vecs.push_back(mk(1, 32'h200,      32'h20, 1, 0, 0, 32'h0,    0, 1, 1, 0, 1, 32'h1104));
    vecs.push_back(mk(1, 32'h200,      32'h20, 1, 0, 1, 32'h400,  1, 1, 1, 0, 1, 32'h1104));
    vecs.push_back(mk(1, 32'h200,      32'h20, 1, 0, 0, 32'h0,    0, 1, 1, 0, 1, 32'h1104));
    vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 0, 32'h0,    0, 0, 1, 0, 1, 32'h1104));
    vecs.push_back(mk(1, 32'h200,      32'h20, 0, 1, 1, 32'h300,  1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h300,      32'h80, 0, 0, 0, 32'h0,    0, 1, 1, 1, 1, 32'h380));
    vecs.push_back(mk(1, 32'h200,      32'h20, 1, 1, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'hFFFFFFFC, 32'h10, 0, 0, 0, 32'h0,    0, 1, 1, 1, 0, 32'hC));
    vecs.push_back(mk(1, 32'h400,      32'h40, 0, 0, 0, 32'h0,    0, 1, 1, 1, 1, 32'h440));

    repeat (2) @(negedge clk);
    check("reset pred_valid",  {31'd0, bus.pred_valid}, 32'd0);
    check("reset pred_take",   {31'd0, bus.pred_take},  32'd0);
    check("reset pred_hit",    {31'd0, bus.pred_hit},   32'd0);
    check("reset pred_target", bus.pred_target,         32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.lookup_valid = vecs[i].lv;
      bus.lookup_pc    = vecs[i].pc;
      bus.lookup_imme  = vecs[i].imme;
      bus.stall        = vecs[i].st;
      bus.flush        = vecs[i].fl;
      bus.update_valid = vecs[i].uv;
      bus.update_pc    = vecs[i].upc;
      bus.update_taken = vecs[i].ut;
      @(negedge clk);
      check($sformatf("vec%0d valid", i), {31'd0, bus.pred_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].chk) begin
        check($sformatf("vec%0d take", i),   {31'd0, bus.pred_take}, {31'd0, vecs[i].etake});
        check($sformatf("vec%0d hit", i),    {31'd0, bus.pred_hit},  {31'd0, vecs[i].ehit});
        check($sformatf("vec%0d target", i), bus.pred_target,        vecs[i].etgt);
      end
    end

    // Asynchronous reset mid-operation clears outputs and the valid bits.
    idle_inputs();
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h1100;
    bus.lookup_imme  = 32'h8;
    @(posedge clk);
    #1;
    check("pre-reset valid", {31'd0, bus.pred_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async reset valid",  {31'd0, bus.pred_valid}, 32'd0);
    check("async reset target", bus.pred_target,         32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset hit",    {31'd0, bus.pred_hit},  32'd0);
    check("post-reset take",   {31'd0, bus.pred_take}, 32'd1);
    check("post-reset target", bus.pred_target,        32'h1108);

`ifdef BP_GSHARE_EN
    idle_inputs();
    bus.update_valid = 1'b1;
    bus.update_pc    = 32'h300;
    bus.update_taken = 1'b1;
    @(negedge clk);
    idle_inputs();
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h004;
    bus.lookup_imme  = 32'h10;
    @(negedge clk);
    check("gshare hist",   {24'd0, bus.pred_hist},   32'd1);
    check("gshare miss",   {31'd0, bus.pred_hit},    32'd0);
    check("gshare target", bus.pred_target,          32'h14);
    idle_inputs();
    bus.update_valid = 1'b1;
    bus.update_pc    = 32'h004;
    bus.update_taken = 1'b0;
    bus.update_hist  = 8'd1;
    @(negedge clk);
    idle_inputs();
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h008;
    bus.lookup_imme  = 32'h10;
    @(negedge clk);
    check("gshare hit",     {31'd0, bus.pred_hit},  32'd1);
    check("gshare take",    {31'd0, bus.pred_take}, 32'd0);
    check("gshare target2", bus.pred_target,        32'hC);
    check("gshare hist2",   {24'd0, bus.pred_hist}, 32'd2);
`endif

    idle_inputs();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised successor to the fetch-stage predictor. Direct-mapped, tagged branch history table with N-bit saturating counters.
- Lookup port sits in IF/ID: registered prediction, 1-cycle latency. Update port is driven from EX on branch resolution.
- Word-aligned indexing and a configurable default for misses. Optional global-history (gshare) indexing.
- IF owns the PC mux; this block only predicts.

Parameters:
- INDEX_BITS, 10, table depth = 2**INDEX_BITS entries.
- CTR_BITS, 2, saturating counter width (>=1).
- DEFAULT_TAKE, 1, prediction on table miss (1 = taken).
- HIST_BITS, 8, global history length (used only with BP_GSHARE_EN; must be <= INDEX_BITS).

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- lookup_valid  in  1  branch decoded in ID this cycle
- lookup_pc  in  32  branch PC
- lookup_imme  in  32  branch offset
- stall  in  1  load-use stall; hold prediction registers
- flush  in  1  misprediction flush; kill pending prediction
- pred_valid  out  1  prediction registered this cycle
- pred_take  out  1  predicted direction
- pred_target  out  32  predicted next PC
- pred_hit  out  1  valid tag match found
- update_valid  in  1  branch resolved in EX
- update_pc  in  32  resolved branch PC
- update_taken  in  1  actual outcome
- pred_hist  out  HIST_BITS  history snapshot at lookup (BP_GSHARE_EN only)
- update_hist  in  HIST_BITS  snapshot returned with update (BP_GSHARE_EN only)

Behaviour:
- Clocking and reset: clk; reset asynchronous, active-high.
- Reset:
  - All valid bits clear.
  - pred_valid=0, pred_take=0, pred_hit=0, pred_target=0.
  - History register = 0.
  - Tag and counter arrays are not reset.
  - Reset mid-operation drops any pending prediction or update.
- Address split:
  - idx = pc[INDEX_BITS+1:2].
  - tag = pc[31:INDEX_BITS+2], width 30-INDEX_BITS.
  - pc[1:0] is ignored.
- Lookup:
  - Sampled on a clock edge with lookup_valid=1 and stall=0.
  - Next cycle: pred_valid=1.
  - hit = valid[idx] && tag match.
  - take = hit ? ctr[CTR_BITS-1] : DEFAULT_TAKE.
  - pred_target = take ? lookup_pc+lookup_imme : lookup_pc+4, 32-bit wrap-around.
- Output registers:
  - pred_valid is a one-cycle pulse when stall=0 and no new lookup.
  - stall=1 holds all pred_* registers unchanged.
  - flush=1 forces pred_valid=0 next cycle and overrides lookup_valid. Updates still apply.
- Update (one edge, update_valid=1):
  - Hit: counter saturating +1 if taken, -1 if not taken. Clamps at all-ones and at 0.
  - Miss or invalid: allocate the entry. Set valid, write tag, counter = 10..0 (weak taken) if taken, else 01..1 (weak not-taken).
  - CTR_BITS=1: counter = outcome.
  - Updates are never blocked by stall.
- Simultaneous lookup and update to the same idx: write-first bypass. The lookup sees the post-update entry (valid, tag, counter).
- Counter state names (CTR_BITS=2): 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff MSB=1.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - HIST_BITS global history register, shifted left with update_taken on every update_valid.
  - Lookup idx = pc idx XOR zero-extended history; pred_hist = history sampled at lookup.
  - Update idx = update_pc idx XOR update_hist. Tag is computed unchanged.
  - flush does not restore history.
- Undefined:
  - pred_hist and update_hist ports are absent.
  - Pure PC indexing.

Decomposition:
- Shared package bp_pkg holds:
  - counter state constants: CTR_STRONG_NT, CTR_WEAK_NT, CTR_WEAK_T, CTR_STRONG_T;
  - function ctr_next(ctr, taken);
  - function weak_init(taken).
- One sub-module, bp_table: valid/tag/counter storage with one read and one write port plus the bypass logic. The top holds the output registers and history.

Test Plan:
- Reset, then lookup pc=0x100, imme=0x40 -> next cycle pred_valid=1, pred_hit=0, pred_take=1, pred_target=0x140.
- Update pc=0x100 not-taken once, then lookup -> hit=1, ctr=01, take=0, target=0x104. A second not-taken update -> ctr=00. A third -> stays 00 (saturation).
- Aliasing: allocate 0x100. Update pc=0x100+(4<<INDEX_BITS) not-taken -> tag replaced; lookup 0x100 -> miss, DEFAULT_TAKE.
- Same-cycle update(0x200, taken) and lookup(0x200) on an empty table -> pred_hit=1, take=1 via bypass.
- stall=1 for 3 cycles after a prediction -> pred_* held. flush with lookup_valid=1 -> pred_valid=0.
- BP_GSHARE_EN: history 0b1 -> lookup 0x004 uses idx 0, returned pred_hist=1. An update with update_hist=1 hits the same entry.
